// File: rtl/ifetch_if.sv
// Fetch-unit bundle: controller strobes, instruction-memory read port and instruction output.
// master = fetch unit, slave = controller/memory side.
interface ifetch_if #(
  parameter int ADDR_W = 16
);
  logic              fetch;
  logic              jmp;
  logic [ADDR_W-1:0] jmp_addr;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_data;
  logic [7:0]        instr;
  logic              instr_valid;
  logic [ADDR_W-1:0] pc;

  modport master (
    input  fetch, jmp, jmp_addr, mem_ack, mem_data,
    output mem_req, mem_addr, instr, instr_valid, pc
  );

  modport slave (
    output fetch, jmp, jmp_addr, mem_ack, mem_data,
    input  mem_req, mem_addr, instr, instr_valid, pc
  );
endinterface

// File: rtl/ifetch.sv
// Byte instruction fetcher: IDLE/REQ/FLUSH FSM, one read outstanding, head valid the cycle after capture; stalls when the buffer is full.
// `IFETCH_PREFETCH_EN selects a 2-entry prefetch FIFO; otherwise a single instruction register.
module ifetch #(
  parameter int ADDR_W = 16
) (
  input logic      clk,
  input logic      rst,
  ifetch_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, FLUSH} state_t;

`ifdef IFETCH_PREFETCH_EN
  localparam logic [1:0] CAP = 2'd2;
`else
  localparam logic [1:0] CAP = 2'd1;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] flush_addr_q;
  logic [1:0]        cnt_q;
  logic [1:0]        cnt_after_pop;
  logic              pop;
  logic              push;
  logic              redirect;
  logic [7:0]        head;

  assign redirect      = bus.jmp;
  assign pop           = bus.fetch && (cnt_q != 2'd0) && !bus.jmp;
  assign cnt_after_pop = cnt_q - {1'b0, pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.jmp) begin
          pc_d    = bus.jmp_addr;
          state_d = REQ;
        end else if (cnt_after_pop < CAP) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.jmp) begin
          // A response landing with the redirect is stale; otherwise drain it in FLUSH.
          pc_d    = bus.jmp_addr;
          state_d = bus.mem_ack ? REQ : FLUSH;
        end else if (bus.mem_ack) begin
          push    = 1'b1;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = ((cnt_after_pop + 2'd1) < CAP) ? REQ : IDLE;
        end
      end
      FLUSH: begin
        if (bus.jmp) begin
          pc_d = bus.jmp_addr;
        end
        if (bus.mem_ack) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= '0;
      flush_addr_q <= '0;
    end else begin
      pc_q <= pc_d;
      // Keeps the outstanding address on the bus after pc has been redirected.
      if (state_q == REQ) begin
        flush_addr_q <= pc_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 2'd0;
    end else if (redirect) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef IFETCH_PREFETCH_EN
  logic [7:0] buf0_q, buf1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf0_q <= 8'h00;
      buf1_q <= 8'h00;
    end else if (!redirect) begin
      if (pop) begin
        buf0_q <= (push && cnt_q == 2'd1) ? bus.mem_data : buf1_q;
        if (push && cnt_q == 2'd2) begin
          buf1_q <= bus.mem_data;
        end
      end else if (push) begin
        if (cnt_q == 2'd0) begin
          buf0_q <= bus.mem_data;
        end else begin
          buf1_q <= bus.mem_data;
        end
      end
    end
  end

  assign head = buf0_q;
`else
  logic [7:0] buf0_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf0_q <= 8'h00;
    end else if (push) begin
      buf0_q <= bus.mem_data;
    end
  end

  assign head = buf0_q;
`endif

  assign bus.mem_req     = (state_q != IDLE);
  assign bus.mem_addr    = (state_q == FLUSH) ? flush_addr_q : pc_q;
  assign bus.instr       = head;
  assign bus.instr_valid = (cnt_q != 2'd0);
  assign bus.pc          = pc_q;

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter ADDR_W, default 16, SHALL set the width of the program counter and memory address.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on posedge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 fetch  input  1  SHALL be the consume strobe from the controller; the head instruction pops when fetch is high at a posedge with instr_valid=1.
REQ-005 jmp  input  1  SHALL be the redirect strobe, sampled at posedge.
REQ-006 jmp_addr  input  ADDR_W  SHALL be the redirect target, valid when jmp=1.
REQ-007 mem_req  output  1  SHALL be the read request to instruction memory.
REQ-008 mem_addr  output  ADDR_W  SHALL be the read address, stable while mem_req=1.
REQ-009 mem_ack  input  1  SHALL complete a read when high at a posedge with mem_req=1.
REQ-010 mem_data  input  8  SHALL carry the read byte, valid when mem_ack=1.
REQ-011 instr  output  8  SHALL present the head instruction to the controller.
REQ-012 instr_valid  output  1  SHALL indicate that instr holds an unconsumed instruction.
REQ-013 pc  output  ADDR_W  SHALL expose the address of the next byte to be requested.

Function
REQ-014 The FSM SHALL have states IDLE (no request), REQ (mem_req=1, mem_addr=pc) and FLUSH (mem_req=1, response discarded).
REQ-015 IDLE SHALL go to REQ on the posedge at which the buffer has room (after any pop that cycle).
REQ-016 In REQ, mem_ack=1 SHALL write mem_data into the buffer, increment pc by 1 modulo 2^ADDR_W (all-ones wraps to zero), and go to REQ if room remains, else IDLE.
REQ-017 mem_req SHALL stay high with mem_addr unchanged until mem_ack; no request is withdrawn early.
REQ-018 instr_valid SHALL rise on the posedge that captures a response into an empty buffer; instr SHALL equal that byte in the same cycle.
REQ-019 fetch with instr_valid=0 SHALL be ignored.
REQ-020 A pop and a capture on the same posedge SHALL both take effect; occupancy is unchanged and order is preserved.
REQ-021 jmp=1 SHALL empty the buffer, drop instr_valid, and load pc<=jmp_addr on that posedge; jmp overrides fetch in that cycle.
REQ-022 jmp in REQ without mem_ack SHALL go to FLUSH; FLUSH SHALL hold mem_req and old mem_addr until mem_ack, discard mem_data, then go to REQ at the new pc.
REQ-023 jmp in REQ with mem_ack on the same posedge SHALL discard mem_data and go directly to REQ at jmp_addr.
REQ-024 A second jmp during FLUSH SHALL update pc; FLUSH continues until the outstanding ack arrives.

Reset
REQ-025 Asserting rst SHALL immediately set pc=0, mem_req=0, instr=8'h00, instr_valid=0, buffer empty, state IDLE, independent of clk.
REQ-026 A memory transaction in flight at reset SHALL be abandoned; a late mem_ack after reset release SHALL be ignored unless mem_req=1.
REQ-027 After rst deasserts, the first posedge SHALL enter REQ with mem_addr=0.

Configuration
REQ-028 With IFETCH_PREFETCH_EN defined, the buffer SHALL be a 2-entry FIFO; requests continue while fewer than 2 entries are held.
REQ-029 Without IFETCH_PREFETCH_EN, the buffer SHALL be a single instruction register; a request is issued only while it is empty or being popped in the same cycle.

Verification
REQ-030 Reset release, memory acks every request with data=addr[7:0] -> instr sequence 00,01,02,... with instr_valid first high one cycle after first ack.
REQ-031 fetch held low, prefetch enabled -> exactly 2 reads (addr 0,1), then mem_req=0, pc=2; disabled -> 1 read, pc=1.
REQ-032 jmp_addr=16'h0040 while request to 0x0005 is stalled 3 cycles -> mem_addr stays 0x0005 until ack, data discarded, next request at 0x0040, next instr=8'h40.
REQ-033 pc at 16'hFFFF, ack -> pc=16'h0000 and next mem_addr=0x0000.
REQ-034 rst asserted mid-clock during outstanding request -> mem_req and instr_valid drop without a clock edge; after release first mem_addr=0.
REQ-035 fetch and mem_ack on the same posedge with one entry held -> popped entry leaves, new byte becomes head, instr_valid stays 1.
